// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot stage in front of the processor. Receives a framed program image on a
// valid/ready word stream (header, N payload words, checksum), writes the
// payload into instruction memory, and keeps the core in reset while the image
// is incomplete. Once the checksum matches the running payload sum, it issues
// a one-cycle start pulse and releases the core.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   load_req             one-cycle request to begin a load (from IDLE or ERROR)
//   abort                cancel the current load, return to IDLE
//   in_data/in_valid     stream word and its qualifier
//   in_ready             registered: loader accepts a word this cycle
//   im_wr_en/addr/data   registered instruction-memory write port (byte address)
//   proc_hold            hold the processor in reset
//   start                one-cycle launch pulse
//   busy                 loader is in HDR, LOAD or CHK
//   error/err_code       sticky failure: 1 bad magic, 2 bad length, 3 bad checksum
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256,
    parameter logic [15:0]       MAGIC     = 16'hA5C3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [DATA_W-1:0] im_wr_data,
    output logic              proc_hold,
    output logic              start,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              in_ready_q, in_ready_d;
    logic              im_wr_en_q, im_wr_en_d;
    logic [ADDR_W-1:0] im_wr_addr_q, im_wr_addr_d;
    logic [DATA_W-1:0] im_wr_data_q, im_wr_data_d;
    logic              proc_hold_q, proc_hold_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic [15:0]       hdr_magic;
    logic [15:0]       hdr_len;

    assign accept    = in_valid && in_ready_q;
    assign hdr_magic = in_data[31:16];
    assign hdr_len   = in_data[15:0];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        len_d        = len_q;
        sum_d        = sum_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        im_wr_en_d   = 1'b0;
        im_wr_addr_d = im_wr_addr_q;
        im_wr_data_d = im_wr_data_q;

        // abort overrides everything, including a word accepted this cycle
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (load_req) begin
                        state_d    = S_HDR;
                        error_d    = 1'b0;
                        err_code_d = 2'd0;
                        count_d    = '0;
                        sum_d      = '0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (hdr_magic != MAGIC) begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'd1;
                        end else if (hdr_len == 16'd0 ||
                                     {16'd0, hdr_len} > 32'(MAX_WORDS)) begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'd2;
                        end else begin
                            len_d   = CNT_W'(hdr_len);
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        im_wr_en_d   = 1'b1;
                        // byte address of word i; wraps naturally at ADDR_W bits
                        im_wr_addr_d = BASE_ADDR + (ADDR_W'(count_q) << 2);
                        im_wr_data_d = in_data;
                        sum_d        = sum_q + in_data;
                        count_d      = count_q + CNT_W'(1);
                        if (count_q + CNT_W'(1) == len_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = 2'd3;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decodes of the next state so they line up with state_q.
        // ERROR keeps the core held so a partial image never runs.
        in_ready_d  = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CHK);
        busy_d      = in_ready_d;
        proc_hold_d = (state_d != S_IDLE);
        start_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            len_q        <= '0;
            sum_q        <= '0;
            error_q      <= 1'b0;
            err_code_q   <= 2'd0;
            in_ready_q   <= 1'b0;
            im_wr_en_q   <= 1'b0;
            im_wr_addr_q <= '0;
            im_wr_data_q <= '0;
            proc_hold_q  <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            in_ready_q   <= in_ready_d;
            im_wr_en_q   <= im_wr_en_d;
            im_wr_addr_q <= im_wr_addr_d;
            im_wr_data_q <= im_wr_data_d;
            proc_hold_q  <= proc_hold_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign im_wr_en   = im_wr_en_q;
    assign im_wr_addr = im_wr_addr_q;
    assign im_wr_data = im_wr_data_q;
    assign proc_hold  = proc_hold_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic        abort;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_wr_en;
    logic [31:0] im_wr_addr;
    logic [31:0] im_wr_data;
    logic        proc_hold;
    logic        start;
    logic        busy;
    logic        error;
    logic [1:0]  err_code;

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .proc_hold  (proc_hold),
        .start      (start),
        .busy       (busy),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Observed IM writes and start pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (im_wr_en) obs_q.push_back({im_wr_addr, im_wr_data});
        if (start) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Present one word and hold it until accepted (bounded), optionally idle a cycle after
    task automatic send_word(input logic [31:0] w, input bit gap);
        bit ok;
        ok       = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted within 20 cycles", w);
        end
        if (gap) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; load_req = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, im_wr_en, proc_hold, start, busy, error, err_code} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {in_ready, im_wr_en, proc_hold, start, busy, error, err_code});
        end
        checks++;
        if ({im_wr_addr, im_wr_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_im: got %h required 0", {im_wr_addr, im_wr_data});
        end
    endtask

    task automatic test_basic_load(input bit gap, input string tag);
        logic [31:0] words [3];
        logic [63:0] e, o;
        int          s0;
        words = '{32'd11, 32'd22, 32'd33};
        exp_q.delete(); obs_q.delete();
        s0 = start_cnt;
        pulse_load();
        checks++;
        if ({in_ready, busy, proc_hold} !== 3'b111) begin
            errors++;
            $display("FAIL %s_hdr_state: got %b required 111", tag, {in_ready, busy, proc_hold});
        end
        send_word(32'hA5C3_0003, gap);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'(4 * i), words[i]});
            send_word(words[i], gap);
            if (i == 0 && !gap) begin
                checks++;
                if ({im_wr_en, im_wr_addr, im_wr_data} !== {1'b1, 32'h0, 32'd11}) begin
                    errors++;
                    $display("FAIL %s_write_latency: got en=%b a=%h d=%h required en=1 a=0 d=11",
                             tag, im_wr_en, im_wr_addr, im_wr_data);
                end
            end
        end
        send_word(32'd66, 1'b0);
        if (gap) begin
            checks++;
            if ({start, proc_hold} !== 2'b11) begin
                errors++;
                $display("FAIL %s_start_gap: got %b required 11", tag, {start, proc_hold});
            end
            tick();
        end else begin
            checks++;
            if ({start, proc_hold} !== 2'b11) begin
                errors++;
                $display("FAIL %s_start_on: got start,hold=%b required 11", tag, {start, proc_hold});
            end
            tick();
        end
        checks++;
        if ({start, proc_hold, busy, in_ready, error} !== 5'b0) begin
            errors++;
            $display("FAIL %s_start_off: got %b required 00000", tag,
                     {start, proc_hold, busy, in_ready, error});
        end
        tick();
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL %s_start_count: got %0d required 1", tag, start_cnt - s0);
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL %s_write_count: got %0d required 3", tag, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s_write: got %h required %h", tag, o, e);
            end
        end
    endtask

    task automatic test_bad_magic();
        obs_q.delete();
        pulse_load();
        send_word(32'h1234_0003, 1'b0);
        checks++;
        if ({error, err_code, in_ready, busy, proc_hold} !== 6'b101001) begin
            errors++;
            $display("FAIL magic_err: got err,code,rdy,busy,hold=%b required 101001",
                     {error, err_code, in_ready, busy, proc_hold});
        end
        repeat (3) tick();
        checks++;
        if ({proc_hold, error} !== 2'b11 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL magic_hold: got hold,err=%b writes=%0d required 11 and 0",
                     {proc_hold, error}, obs_q.size());
        end
        pulse_load();
        checks++;
        if ({error, err_code, proc_hold, busy} !== 5'b00011) begin
            errors++;
            $display("FAIL magic_reload_clear: got %b required 00011",
                     {error, err_code, proc_hold, busy});
        end
        do_abort();
    endtask

    task automatic test_bad_length();
        pulse_load();
        send_word(32'hA5C3_0000, 1'b0);
        checks++;
        if ({error, err_code} !== 3'b110) begin
            errors++;
            $display("FAIL len_zero: got err,code=%b required 110", {error, err_code});
        end
        pulse_load();
        send_word(32'hA5C3_0101, 1'b0);
        checks++;
        if ({error, err_code} !== 3'b110) begin
            errors++;
            $display("FAIL len_257: got err,code=%b required 110", {error, err_code});
        end
        // abort from ERROR: returns to IDLE, releases the core, leaves error as is
        do_abort();
        checks++;
        if ({error, err_code, proc_hold, busy} !== 5'b11000) begin
            errors++;
            $display("FAIL err_abort: got %b required 11000", {error, err_code, proc_hold, busy});
        end
        // N == MAX_WORDS is legal
        pulse_load();
        send_word(32'hA5C3_0100, 1'b0);
        checks++;
        if ({error, busy, in_ready} !== 3'b011) begin
            errors++;
            $display("FAIL len_256: got err,busy,rdy=%b required 011", {error, busy, in_ready});
        end
        do_abort();
    endtask

    task automatic test_bad_checksum();
        logic [63:0] e, o;
        int          s0;
        exp_q.delete(); obs_q.delete();
        s0 = start_cnt;
        pulse_load();
        send_word(32'hA5C3_0003, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'(4 * i), 32'(11 * (i + 1))});
            send_word(32'(11 * (i + 1)), 1'b0);
        end
        send_word(32'd67, 1'b0);
        repeat (2) tick();
        checks++;
        if ({error, err_code, proc_hold} !== 4'b1111) begin
            errors++;
            $display("FAIL chk_err: got err,code,hold=%b required 1111", {error, err_code, proc_hold});
        end
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL chk_no_start: got %0d pulses required 0", start_cnt - s0);
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL chk_write_count: got %0d required 3", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL chk_write: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_abort_reset();
        logic [63:0] e, o;
        int          s0;
        exp_q.delete(); obs_q.delete();
        s0 = start_cnt;
        pulse_load();
        send_word(32'hA5C3_0003, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({32'(4 * i), 32'(11 * (i + 1))});
            send_word(32'(11 * (i + 1)), 1'b0);
        end
        // abort coincides with an offered word while in_ready is high
        in_data = 32'd33; in_valid = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, proc_hold, im_wr_en, error, start} !== 6'b0) begin
            errors++;
            $display("FAIL abort_state: got busy,rdy,hold,wr,err,start=%b required 000000",
                     {busy, in_ready, proc_hold, im_wr_en, error, start});
        end
        tick();
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL abort_write_count: got %0d required 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_write: got %h required %h", o, e);
            end
        end
        // reset during HDR with a header being accepted
        pulse_load();
        in_data = 32'hA5C3_0003; in_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, im_wr_en, im_wr_addr, im_wr_data, proc_hold, start, busy, error, err_code}
            !== 72'd0) begin
            errors++;
            $display("FAIL reset_hdr: got rdy=%b wr=%b a=%h d=%h hold=%b start=%b busy=%b err=%b code=%0d required all 0",
                     in_ready, im_wr_en, im_wr_addr, im_wr_data, proc_hold, start, busy, error, err_code);
        end
        // reset during LOAD with a payload word being accepted: no write from it
        obs_q.delete();
        pulse_load();
        send_word(32'hA5C3_0003, 1'b0);
        in_data = 32'h0BAD_F00D; in_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (obs_q.size() != 0 || {im_wr_en, busy, proc_hold} !== 3'b0) begin
            errors++;
            $display("FAIL reset_load: got writes=%0d wr,busy,hold=%b required 0 and 000",
                     obs_q.size(), {im_wr_en, busy, proc_hold});
        end
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL abort_no_start: got %0d pulses required 0", start_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load(1'b0, "streamed");
        test_basic_load(1'b1, "stalled");
        test_bad_magic();
        test_bad_length();
        test_bad_checksum();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
